// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog
//   Single-clock FIFO with arbitrary depth, runtime-programmable
//   almost-full/almost-empty thresholds, fill level, synchronous flush,
//   sticky error flags and a selectable first-word-fall-through read port.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   flush               synchronous clear of pointers, count and flags
//   wr_en, data_in      write request and data
//   rd_en               read request (FWFT: acknowledge/pop of head word)
//   af_level, ae_level  almost-full / almost-empty thresholds
//   data_out, rd_valid  read data and its qualifier
//   wr_ack              write accepted (one-cycle pulse)
//   overflow            write rejected while full (one-cycle pulse)
//   underflow           read rejected while empty (one-cycle pulse)
//   ovf_sticky          latched overflow, cleared by reset/flush
//   udf_sticky          latched underflow, cleared by reset/flush
//   full, empty         status decoded from the stored count
//   almostfull          count >= af_level
//   almostempty         count <= ae_level
//   level               current count
module sync_fifo_prog #(
  parameter int  FIFO_WIDTH = 16,
  parameter int  FIFO_DEPTH = 8,
  parameter int  FWFT       = 0,
  localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [LW-1:0]         af_level,
  input  logic [LW-1:0]         ae_level,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ovf_sticky,
  output logic                  udf_sticky,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [LW-1:0]         level
);

  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(FIFO_DEPTH - 1);
  localparam logic [LW-1:0] DEPTH_C = LW'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         count;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almostfull  = (count >= af_level);
  assign almostempty = (count <= ae_level);
  assign level       = count;

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      // Explicit wrap so non-power-of-two depths work.
      if (wr_ok) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      wr_ack    <= wr_ok;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
      if (wr_en & full)  ovf_sticky <= 1'b1;
      if (rd_en & empty) udf_sticky <= 1'b1;
    end
  end

  // Storage is never cleared; reset/flush discard contents via the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem[wr_ptr] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; forced to zero while empty so the
    // port is defined out of reset rather than showing stale storage.
    assign data_out = empty ? '0 : mem[rd_ptr];
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [FIFO_WIDTH-1:0] dout_q;
    logic                  vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else if (flush) begin
        vld_q  <= 1'b0;
      end else begin
        vld_q <= rd_ok;
        if (rd_ok) dout_q <= mem[rd_ptr];
      end
    end

    assign data_out = dout_q;
    assign rd_valid = vld_q;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a registered-read instance and an FWFT instance
// (both depth 5, width 8) share one stimulus stream. A queue-based model
// predicts contents; the expected read words go into a scoreboard queue that
// a separate monitor drains whenever the registered-read instance asserts
// rd_valid.
module tb_sync_fifo_prog;

  localparam int W = 8;
  localparam int D = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [2:0]   af_level = 3'd4;
  logic [2:0]   ae_level = 3'd1;

  logic [W-1:0] data_out, data_out_f;
  logic         rd_valid, rd_valid_f;
  logic         wr_ack, wr_ack_f, overflow, overflow_f, underflow, underflow_f;
  logic         ovf_sticky, ovf_sticky_f, udf_sticky, udf_sticky_f;
  logic         full, full_f, empty, empty_f;
  logic         almostfull, almostfull_f, almostempty, almostempty_f;
  logic [2:0]   level, level_f;

  sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .af_level(af_level), .ae_level(ae_level),
    .data_out(data_out), .rd_valid(rd_valid), .wr_ack(wr_ack),
    .overflow(overflow), .underflow(underflow), .ovf_sticky(ovf_sticky),
    .udf_sticky(udf_sticky), .full(full), .empty(empty),
    .almostfull(almostfull), .almostempty(almostempty), .level(level)
  );

  sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .af_level(af_level), .ae_level(ae_level),
    .data_out(data_out_f), .rd_valid(rd_valid_f), .wr_ack(wr_ack_f),
    .overflow(overflow_f), .underflow(underflow_f), .ovf_sticky(ovf_sticky_f),
    .udf_sticky(udf_sticky_f), .full(full_f), .empty(empty_f),
    .almostfull(almostfull_f), .almostempty(almostempty_f), .level(level_f)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mdl[$];    // model FIFO contents, head at index 0
  logic [W-1:0] exp_q[$];  // expected registered-read words
  bit           m_ovf_s, m_udf_s;
  bit           exp_wack, exp_ovf, exp_udf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every registered-read rd_valid consumes one expected word.
  logic [W-1:0] mon_e;
  always @(negedge clk) begin
    if (rst_n && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("rd_valid_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("data_out", data_out, mon_e);
      end
    end
  end

  task automatic chk_status();
    int n;
    n = mdl.size();
    chk("level", level, n);
    chk("full", full, n == D);
    chk("empty", empty, n == 0);
    chk("almostfull", almostfull, n >= int'(af_level));
    chk("almostempty", almostempty, n <= int'(ae_level));
    chk("level_f", level_f, n);
    chk("almostfull_f", almostfull_f, n >= int'(af_level));
    chk("rd_valid_f", rd_valid_f, n > 0);
    if (n > 0) chk("data_out_f", data_out_f, mdl[0]);
    else       chk("data_out_f_empty", data_out_f, 0);
  endtask

  // One clock of stimulus: drive at negedge, check status before the edge,
  // check pulses/stickies just after it.
  task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit f);
    bit wa, ra;
    @(negedge clk);
    wr_en = w; data_in = d; rd_en = r; flush = f;
    #1;
    chk_status();
    if (f) begin
      exp_wack = 0; exp_ovf = 0; exp_udf = 0;
    end else begin
      exp_wack = w && (mdl.size() < D);
      exp_ovf  = w && (mdl.size() == D);
      exp_udf  = r && (mdl.size() == 0);
    end
    wa = exp_wack;
    ra = !f && r && (mdl.size() > 0);
    if (ra) exp_q.push_back(mdl[0]);
    @(posedge clk);
    #1;
    if (f) begin
      mdl.delete();
      m_ovf_s = 0;
      m_udf_s = 0;
      chk("rd_valid_after_flush", rd_valid, 0);
    end else begin
      if (ra) void'(mdl.pop_front());
      if (wa) mdl.push_back(d);
      m_ovf_s |= exp_ovf;
      m_udf_s |= exp_udf;
    end
    chk("wr_ack", wr_ack, exp_wack);
    chk("overflow", overflow, exp_ovf);
    chk("underflow", underflow, exp_udf);
    chk("ovf_sticky", ovf_sticky, m_ovf_s);
    chk("udf_sticky", udf_sticky, m_udf_s);
    chk("wr_ack_f", wr_ack_f, exp_wack);
    chk("overflow_f", overflow_f, exp_ovf);
    chk("underflow_f", underflow_f, exp_udf);
    chk("udf_sticky_f", udf_sticky_f, m_udf_s);
    wr_en = 0; rd_en = 0; flush = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_almostempty"}, almostempty, 1);
    chk({tag, "_wr_ack"}, wr_ack, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_underflow"}, underflow, 0);
    chk({tag, "_ovf_sticky"}, ovf_sticky, 0);
    chk({tag, "_udf_sticky"}, udf_sticky, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_rd_valid_f"}, rd_valid_f, 0);
    chk({tag, "_data_out_f"}, data_out_f, 0);
  endtask

  initial begin
    int wbias;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Fill to full, then one overflowing write.
    for (int i = 0; i < 5; i++) step(1, 8'h11 + 8'(i), 0, 0);
    step(1, 8'h16, 0, 0);
    // Wrap-around: read 3, write 3, read + write at full, drain.
    repeat (3) step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h21 + 8'(i), 0, 0);
    step(1, 8'h99, 1, 0);               // full: read ok, write overflows
    repeat (4) step(0, 0, 1, 0);
    step(1, 8'h31, 1, 0);               // empty: write ok, read underflows
    step(1, 8'h32, 0, 0);
    step(1, 8'h33, 1, 0);               // level 2: both accepted
    repeat (2) step(0, 0, 1, 0);
    // Threshold sweep with af=4, ae=1; af changed to 2 at level 3.
    for (int i = 0; i < 3; i++) step(1, 8'h40 + 8'(i), 0, 0);
    af_level = 3'd2;
    #1;
    chk("af_change_same_cycle", almostfull, 1);
    af_level = 3'd4;
    #1;
    chk("af_restore", almostfull, 0);
    for (int i = 0; i < 2; i++) step(1, 8'h43 + 8'(i), 0, 0);
    repeat (2) step(0, 0, 1, 0);
    // Flush at level 3 with a write pending.
    step(1, 8'h55, 0, 1);
    step(0, 0, 0, 0);
    // FWFT fall-through of a single word and its pop.
    step(1, 8'hAA, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    // Mid-stream reset with pulses and stickies active.
    for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0, 0);
    step(1, 8'h77, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    mdl.delete();
    exp_q.delete();
    m_ovf_s = 0;
    m_udf_s = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic, thresholds and occasional flushes.
    wbias = 50;
    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) wbias = $urandom_range(20, 80);
      if (c % 37 == 0) begin
        af_level = 3'($urandom_range(0, 7));
        ae_level = 3'($urandom_range(0, 7));
      end
      step($urandom_range(0, 99) < wbias, 8'($urandom),
           $urandom_range(0, 99) >= wbias - 10,
           $urandom_range(0, 59) == 0);
    end

    repeat (2) step(0, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
